// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state type and averaging constants for the ADC scan sequencer.
package adc_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_START,
        S_WAIT_DONE,
        S_STORE
    } state_t;
    localparam int AVG_SAMPLES = 4;
    localparam int AVG_SHIFT = $clog2(AVG_SAMPLES);
endpackage

// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: analog mux select plus SAR converter start/done handshake.
interface adc_scan_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int N_BITS = 8
);
    logic [$clog2(NUM_CH)-1:0] mux_sel;
    logic conv_start;
    logic conv_done;
    logic [N_BITS-1:0] conv_code;
    modport master (output mux_sel, conv_start, input conv_done, conv_code);
    modport slave (input mux_sel, conv_start, output conv_done, conv_code);
endinterface

// File: rtl/adc_seq_timer.sv
// adc_seq_timer: cycle counter that raises expired on its LIMIT-th counted cycle and then holds.
module adc_seq_timer #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expired
);
    localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
    localparam int LAST = LIMIT > 1 ? LIMIT - 1 : 0;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= '0;
        else if (count && !expired) cnt <= cnt + 1'b1;
    end
    assign expired = cnt == W'(LAST);
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin scan of enabled mux channels through one shared SAR converter.
// Define ADC_SEQ_AVG_EN to average AVG_SAMPLES back-to-back conversions per channel visit.
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int N_BITS = 8,
    parameter int SETTLE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [NUM_CH-1:0]         ch_enable,
    adc_scan_sequencer_if.master      conv,
    input  logic [$clog2(NUM_CH)-1:0] rd_ch,
    output logic [N_BITS-1:0]         rd_data,
    output logic [NUM_CH-1:0]         ch_valid,
    output logic                      scan_done,
    output logic                      timeout_err
);
    localparam int CW = $clog2(NUM_CH);
    state_t state, state_nx;
    logic [CW-1:0] ch, nxt_ch, hi_ch;
    logic fresh, settle_exp, to_exp, last_sample;
    logic [N_BITS-1:0] res [NUM_CH];
    logic [N_BITS-1:0] store_val;
    int idx;
    adc_seq_timer #(.LIMIT(SETTLE_CYCLES)) u_settle (
        .clk(clk), .reset(reset), .load(state == S_SELECT), .count(state == S_SETTLE), .expired(settle_exp)
    );
    adc_seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk), .reset(reset), .load(state == S_START), .count(state == S_WAIT_DONE), .expired(to_exp)
    );
    // A fresh pass (after idle/reset) searches from channel 0, otherwise from the one after the current
    always_comb begin
        nxt_ch = ch;
        hi_ch = '0;
        idx = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (k + (fresh ? 0 : int'(ch) + 1)) % NUM_CH;
            if (ch_enable[CW'(idx)]) nxt_ch = CW'(idx);
        end
        for (int k = 0; k < NUM_CH; k++) if (ch_enable[k]) hi_ch = CW'(k);
    end
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      state_nx = run && |ch_enable ? S_SELECT : S_IDLE;
            S_SELECT:    state_nx = |ch_enable ? S_SETTLE : S_IDLE;
            S_SETTLE:    state_nx = settle_exp ? S_START : S_SETTLE;
            S_START:     state_nx = S_WAIT_DONE;
            S_WAIT_DONE: state_nx = conv.conv_done ? (last_sample ? S_STORE : S_START) :
                                    to_exp ? (run ? S_SELECT : S_IDLE) : S_WAIT_DONE;
            S_STORE:     state_nx = run ? S_SELECT : S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            ch <= '0;
            fresh <= 1'b1;
            ch_valid <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) res[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE) fresh <= 1'b1;
            if (state == S_SELECT) begin
                ch <= nxt_ch;
                fresh <= 1'b0;
            end
            if (state == S_WAIT_DONE && !conv.conv_done && to_exp) timeout_err <= 1'b1;
            if (state == S_STORE) begin
                res[ch] <= store_val;
                ch_valid[ch] <= 1'b1;
            end
        end
    end
`ifdef ADC_SEQ_AVG_EN
    logic [N_BITS+1:0] acc;
    logic [AVG_SHIFT-1:0] smp;
    // Accumulator restarts at every channel selection, so a timed-out visit leaves nothing behind
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            smp <= '0;
        end else if (state == S_SELECT) begin
            acc <= '0;
            smp <= '0;
        end else if (state == S_WAIT_DONE && conv.conv_done) begin
            acc <= acc + (N_BITS + 2)'(conv.conv_code);
            smp <= smp + 1'b1;
        end
    end
    assign last_sample = smp == AVG_SHIFT'(AVG_SAMPLES - 1);
    assign store_val = acc[N_BITS+1:AVG_SHIFT];
`else
    logic [N_BITS-1:0] code_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) code_q <= '0;
        else if (state == S_WAIT_DONE && conv.conv_done) code_q <= conv.conv_code;
    end
    assign last_sample = 1'b1;
    assign store_val = code_q;
`endif
    assign conv.mux_sel = state == S_SELECT ? nxt_ch : ch;
    assign conv.conv_start = state == S_START;
    assign scan_done = state == S_STORE && ch == hi_ch;
    assign rd_data = res[rd_ch];
endmodule
